// File: rtl/serial_byte_deserializer.sv
// Reassembles LSB-first serial bits into bytes and queues them in a
// first-word-fall-through FIFO with a valid/ready output.
module serial_byte_deserializer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     ser_in,
   input  logic                     ser_valid,
   input  logic                     ser_sof,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     frame_err,
   output logic [CNT_W-1:0]         byte_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {HUNT, RECV} state_t;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q, frame_err_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

   logic       push;
   logic       push_ok;
   logic       pop;
   logic [7:0] next_byte;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      byte_cnt_d  = byte_cnt_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      next_byte   = {ser_in, shreg_q[7:1]};

      unique case (state_q)
         HUNT: begin
            if (ser_valid && ser_sof) begin
               shreg_d   = {ser_in, 7'd0};
               bit_cnt_d = 3'd1;
               state_d   = RECV;
            end
         end
         RECV: begin
            if (ser_valid && ser_sof) begin
               // restart on the new sof; the partial byte is lost
               frame_err_d = 1'b1;
               shreg_d     = {ser_in, 7'd0};
               bit_cnt_d   = 3'd1;
            end else if (ser_valid) begin
               if (bit_cnt_q == 3'd7) begin
                  push      = 1'b1;
                  shreg_d   = 8'd0;
                  bit_cnt_d = 3'd0;
                  state_d   = HUNT;
               end else begin
                  shreg_d   = next_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      pop     = (count_q != '0) && out_ready;
      push_ok = push && ((count_q != LW'(DEPTH)) || pop);

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_ok) begin
         mem_d[wr_ptr_q] = next_byte;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         byte_cnt_d      = byte_cnt_q + CNT_W'(1);
      end
      if (push && !push_ok) begin
         overflow_d = 1'b1;
      end
      count_d = count_q + LW'(push_ok) - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= HUNT;
         bit_cnt_q   <= 3'd0;
         shreg_q     <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign fifo_level = count_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;
   assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Random and directed stimulus checked against a queue-based model
// of the deserializer and its output FIFO.
module tb_serial_byte_deserializer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic                   clk = 1'b0;
   logic                   clear;
   logic                   ser_in;
   logic                   ser_valid;
   logic                   ser_sof;
   logic [7:0]             out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   overflow;
   logic                   frame_err;
   logic [CNT_W-1:0]       byte_cnt;

   serial_byte_deserializer #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .ser_sof   (ser_sof),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fifo_level(fifo_level),
      .overflow  (overflow),
      .frame_err (frame_err),
      .byte_cnt  (byte_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mq[$];
   bit         rx[$];
   bit         in_byte;
   int         m_cnt;
   bit         m_ovf;
   bit         m_fe;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(bit c, bit v, bit s, bit b, bit r);
      bit done;
      int val;
      if (c) begin
         mq.delete();
         rx.delete();
         in_byte = 0;
         m_cnt   = 0;
         m_ovf   = 0;
         m_fe    = 0;
         return;
      end
      done = 0;
      val  = 0;
      m_fe = 0;
      if (v && s) begin
         if (in_byte) m_fe = 1;
         rx.delete();
         rx.push_back(b);
         in_byte = 1;
      end else if (v && in_byte) begin
         rx.push_back(b);
         if (rx.size() == 8) begin
            for (int i = 0; i < 8; i++) val += int'(rx[i]) << i;
            done = 1;
            rx.delete();
            in_byte = 0;
         end
      end
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (done) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(8'(val));
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("out_data", 32'(out_data), mq.size() > 0 ? 32'(mq[0]) : 32'd0);
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
   endtask

   task automatic cyc(bit c, bit v, bit s, bit b, bit r);
      clear     = c;
      ser_valid = v;
      ser_sof   = s;
      ser_in    = b;
      out_ready = r;
      model_step(c, v, s, b, r);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send_byte(logic [7:0] b, bit r, bit r_last);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, i == 0, b[i], i == 7 ? r_last : r);
      end
   endtask

   initial begin
      logic [7:0] aa;
      logic [7:0] x;
      int         rdy_pct;
      aa = 8'hAA;

      cyc(1, 0, 0, 0, 0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_level", 32'(fifo_level), 32'd0);

      // single byte, no consumer
      send_byte(8'hCC, 0, 0);
      chk("plan_cc_data", 32'(out_data), 32'hCC);
      chk("plan_cc_level", 32'(fifo_level), 32'd1);
      chk("plan_cc_cnt", 32'(byte_cnt), 32'd1);

      // back-to-back with consumer ready
      cyc(1, 0, 0, 0, 0);
      send_byte(8'hCC, 1, 1);
      chk("plan_b2b_first", 32'(out_data), 32'hCC);
      send_byte(8'hAA, 1, 1);
      chk("plan_b2b_second", 32'(out_data), 32'hAA);
      cyc(0, 0, 0, 0, 1);
      chk("plan_b2b_empty", 32'(out_valid), 32'd0);
      chk("plan_b2b_cnt", 32'(byte_cnt), 32'd2);

      // overflow with five bytes into four entries
      cyc(1, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0, 0);
      chk("plan_ovf_level", 32'(fifo_level), 32'd4);
      chk("plan_ovf_flag", 32'(overflow), 32'd1);
      chk("plan_ovf_cnt", 32'(byte_cnt), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("plan_ovf_drain", 32'(out_data), 32'(i));
         cyc(0, 0, 0, 0, 1);
      end
      chk("plan_ovf_drained", 32'(out_valid), 32'd0);

      // sof on the 5th bit of a partial byte
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 1, aa[0], 0);
      chk("plan_fe_pulse", 32'(frame_err), 32'd1);
      cyc(0, 1, 0, aa[1], 0);
      chk("plan_fe_once", 32'(frame_err), 32'd0);
      for (int i = 2; i < 8; i++) cyc(0, 1, 0, aa[i], 0);
      chk("plan_fe_cnt", 32'(byte_cnt), 32'd1);
      chk("plan_fe_data", 32'(out_data), 32'hAA);

      // full FIFO, pop coincides with the completing bit
      cyc(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0, 0);
      send_byte(8'h5A, 0, 1);
      chk("plan_full_level", 32'(fifo_level), 32'd4);
      chk("plan_full_ovf", 32'(overflow), 32'd0);
      chk("plan_full_head", 32'(out_data), 32'd2);

      // clear mid-byte with bytes queued
      cyc(1, 0, 0, 0, 0);
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 0);
      cyc(1, 1, 0, 1, 0);
      chk("plan_clr_valid", 32'(out_valid), 32'd0);
      chk("plan_clr_cnt", 32'(byte_cnt), 32'd0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
      chk("plan_clr_ignored", 32'(fifo_level), 32'd0);

      // random traffic
      rdy_pct = 50;
      for (int n = 0; n < 4000; n++) begin
         bit v, s, b, r, c;
         if (n % 250 == 0) rdy_pct = $urandom_range(0, 100);
         c = ($urandom_range(0, 599) == 0);
         v = ($urandom_range(0, 3) != 0);
         if (in_byte) s = ($urandom_range(0, 29) == 0);
         else s = ($urandom_range(0, 2) == 0);
         x = 8'($urandom);
         b = x[0];
         r = ($urandom_range(1, 100) <= rdy_pct);
         cyc(c, v, s, b, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_byte_deserializer.md
Name: serial_byte_deserializer

Overview:
- Downstream stage of the ROM-driven bit serializer.
- Consumes its 1-bit serial stream, sent LSB first with bit index 0..7 per byte, and reassembles 8-bit bytes.
- Buffers reassembled bytes in a small first-word-fall-through FIFO with a valid/ready output handshake.
- Reports framing errors, overflow and an accepted-byte count for checking the round trip against ROM contents.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 16, width of accepted-byte counter

Ports:
clk  input  1  clock; all state updates on rising edge
clear  input  1  synchronous active-high reset
ser_in  input  1  serial data bit
ser_valid  input  1  ser_in is a valid bit this cycle
ser_sof  input  1  start-of-byte marker; meaningful only with ser_valid; marks bit 0
out_data  output  8  FIFO head byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data when out_valid&out_ready
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy 0..DEPTH
overflow  output  1  sticky; set when a completed byte is dropped
frame_err  output  1  one-cycle pulse on framing error
byte_cnt  output  CNT_W  count of bytes pushed into FIFO, wraps

Behaviour:
- Reset (clear=1 at a rising edge):
  - State HUNT; bit_cnt=0; shift register=0.
  - FIFO emptied: out_valid=0, fifo_level=0, out_data=0.
  - overflow=0, frame_err=0, byte_cnt=0.
  - clear overrides every other input in that cycle, including mid-byte and mid-pop.
- Bit ordering: LSB first. Each accepted bit shifts in at bit 7 (shreg <= {ser_in, shreg[7:1]}). After 8 bits, bit 0 is the first bit received.
- FSM, HUNT:
  - Bits with ser_valid=1 and ser_sof=0 are ignored.
  - ser_valid&ser_sof: capture the bit as bit 0, set bit_cnt=1, go to RECV.
- FSM, RECV:
  - Each ser_valid bit with ser_sof=0 shifts in and increments bit_cnt.
  - On the 8th bit (bit_cnt==7 while the bit is valid), the assembled byte {ser_in, shreg[7:1]} is pushed at that same edge. bit_cnt returns to 0 and the state returns to HUNT.
  - ser_valid=0 cycles stall the FSM; there is no timeout.
- Framing error: ser_valid&ser_sof in RECV.
  - Partial byte discarded.
  - frame_err=1 for exactly the next cycle.
  - The sof bit is taken as bit 0 of a new byte; bit_cnt=1, stay in RECV.
  - ser_sof coincident with the 8th bit is also a framing error; the partial byte is not pushed.
- Push:
  - If fifo_level<DEPTH, or a pop happens in the same cycle: write the byte and increment byte_cnt (wraps at 2^CNT_W).
  - Otherwise: drop the byte, set overflow, leave byte_cnt unchanged.
- Pop: out_valid&out_ready advances the head at the edge. out_ready while empty has no effect.
- Simultaneous push and pop:
  - When full: both succeed, level stays DEPTH, no overflow.
  - When empty: the pop is a no-op and the push succeeds.
- Output latency:
  - A byte completed at edge N is visible on out_data with out_valid=1 from edge N if the FIFO was empty. There is no combinational path from ser_in to out_data.
  - Otherwise it appears when it reaches the head.
- fifo_level, out_valid and out_data are registered/derived from registered FIFO pointers. Pointers wrap modulo DEPTH, and a separate occupancy count distinguishes full from empty.
- overflow stays set until clear.

Test Plan:
- Bits 0,0,1,1,0,0,1,1 on consecutive cycles, ser_sof with the first, out_ready=0 -> one edge after the 8th bit: out_valid=1, out_data=0xCC, fifo_level=1, byte_cnt=1.
- Back-to-back 0xCC then 0xAA (bits 0,1,0,1,0,1,0,1), out_ready=1 -> out_data 0xCC then 0xAA, each popped once; byte_cnt=2, overflow=0.
- out_ready=0, push 5 bytes 0x01..0x05 (DEPTH=4) -> fifo_level=4 and overflow=1 after the 5th; byte_cnt=4; draining yields 0x01..0x04 only.
- Start a byte, assert ser_sof on its 5th bit, then send a full 0xAA from that sof -> frame_err pulses one cycle; only 0xAA is pushed; byte_cnt=1.
- FIFO full, out_ready=1 on the same cycle the 8th bit of 0x5A arrives -> head popped, 0x5A accepted, fifo_level stays 4, overflow stays 0.
- clear=1 after 3 bits of a byte with 2 bytes queued -> next cycle out_valid=0, fifo_level=0, byte_cnt=0, state HUNT; the remaining 5 bits without sof are ignored.
